// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_e;

  function automatic int clk_per_bit(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Serial line plus parallel word handshake.
// The tx end drives sig; the rx end drives data/valid.
interface uart_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sig;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport tx (
    output sig,
    input  data,
    input  valid,
    output ready
  );

  modport rx (
    input  sig,
    output data,
    output valid,
    input  ready
  );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs.
// Both stages reset high so an idle line reads as idle.
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data (LSB first), 1 stop.
// Good words are held on data/valid until accepted via ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic clk,
  input  logic rst,
  uart_if.rx   rxif,
  output logic frame_err,
  output logic overrun
);

  localparam int CPB = clk_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB);
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_MID  = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  logic s_sig;

  uart_rx_state_e        state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [IW-1:0]         idx, idx_d;
  logic [DATA_WIDTH-1:0] shreg, sh_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  load, ovr, ferr;

  uart_sync #(
    .WIDTH(1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rxif.sig),
    .q  (s_sig)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    idx_d   = idx;
    sh_d    = shreg;
    load    = 1'b0;
    ovr     = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (s_sig) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (!s_sig) state_d = START;
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = s_sig ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d      = '0;
          sh_d[idx]  = s_sig;
          if (idx == IDX_LAST) state_d = STOP;
          else idx_d = idx + IW'(1);
        end
      end
      STOP: begin
        // Leaving mid-stop-bit keeps the next start edge in view.
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (!s_sig) begin
            ferr    = 1'b1;
            state_d = WAIT_IDLE;
          end else begin
            state_d = IDLE;
            if (valid_q && !rxif.ready) ovr  = 1'b1;
            else                        load = 1'b1;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shreg <= sh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= ovr;
      if (load) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
      end else if (valid_q && rxif.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rxif.data  = data_q;
  assign rxif.valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random
// frames, compared every cycle against a frame-level event model.
module tb_uart_rx;

  localparam int CPB = 10;
  localparam int LAT = 2 + CPB / 2 + (8 + 1) * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_err, overrun;
  logic rdy_dir = 1'b1;
  logic rr_en = 1'b0;
  logic rr_val = 1'b0;

  uart_if #(.DATA_WIDTH(8)) rxif ();

  assign rxif.ready = rr_en ? rr_val : rdy_dir;

  uart_rx #(
    .DATA_WIDTH(8),
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxif     (rxif),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rr_val <= 1'($urandom_range(0, 1));

  // Expected frame outcomes keyed by the clock edge that resolves them.
  logic [7:0] ev_data [int];
  bit         ev_ok   [int];
  int         ev_sched[int];

  int         cyc      = 0;
  int         last_rst = -1;
  logic       valid_m  = 1'b0;
  logic [7:0] data_m   = 8'h00;
  logic       fe_m     = 1'b0;
  logic       ov_m     = 1'b0;

  always @(posedge clk) begin
    int   e;
    logic nv;
    e = cyc + 1;
    fe_m <= 1'b0;
    ov_m <= 1'b0;
    if (rst) begin
      valid_m  <= 1'b0;
      data_m   <= 8'h00;
      last_rst = e;
    end else begin
      nv = valid_m && !rxif.ready;
      if (ev_ok.exists(e) && ev_sched[e] >= last_rst) begin
        if (!ev_ok[e]) fe_m <= 1'b1;
        else if (valid_m && !rxif.ready) ov_m <= 1'b1;
        else begin
          data_m <= ev_data[e];
          nv     = 1'b1;
        end
      end
      valid_m <= nv;
    end
    cyc <= cyc + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] w, input logic stop_ok);
    ev_data[cyc + LAT]  = w;
    ev_ok[cyc + LAT]    = stop_ok;
    ev_sched[cyc + LAT] = cyc;
    rxif.sig = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxif.sig = w[i];
      idle(CPB);
    end
    rxif.sig = stop_ok;
    idle(CPB);
    rxif.sig = 1'b1;
  endtask

  initial begin
    int fe0, ov0;
    logic [7:0] w;
    logic ok;
    rxif.sig = 1'b1;
    fork
      begin
        idle(3);
        check("reset valid", 32'(rxif.valid), 0);
        check("reset data", 32'(rxif.data), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset overrun", 32'(overrun), 0);
        rst = 1'b0;
        idle(5);

        // Single word, ready held high.
        rdy_dir = 1'b1;
        fork
          send(8'hA5, 1'b1);
          begin
            repeat (LAT - 1) @(posedge clk);
            @(negedge clk);
            check("a5 valid before", 32'(rxif.valid), 0);
            @(negedge clk);
            check("a5 valid", 32'(rxif.valid), 1);
            check("a5 data", 32'(rxif.data), 32'hA5);
            @(negedge clk);
            check("a5 valid after", 32'(rxif.valid), 0);
          end
        join
        idle(20);

        // Bad stop bit followed by a long break.
        fe0 = fe_cnt;
        send(8'h81, 1'b0);
        check("81 no valid", 32'(rxif.valid), 0);
        rxif.sig = 1'b0;
        idle(30 * CPB);
        rxif.sig = 1'b1;
        idle(20);
        rdy_dir = 1'b0;
        send(8'h55, 1'b1);
        check("break fe count", 32'(fe_cnt - fe0), 1);
        check("55 data", 32'(rxif.data), 32'h55);
        rdy_dir = 1'b1;
        idle(20);

        // Short glitch must be rejected.
        rdy_dir = 1'b0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rxif.sig = 1'b0;
        idle(3);
        rxif.sig = 1'b1;
        idle(20);
        check("glitch valid", 32'(rxif.valid), 0);
        check("glitch errs", 32'(fe_cnt - fe0 + ov_cnt - ov0), 0);
        send(8'h12, 1'b1);
        check("12 data", 32'(rxif.data), 32'h12);
        idle(20);

        // Reset mid-frame drops held word and the frame.
        fork
          send(8'hF0, 1'b1);
          begin
            idle(53);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("rst valid", 32'(rxif.valid), 0);
            check("rst data", 32'(rxif.data), 0);
            check("rst errs", 32'({frame_err, overrun}), 0);
            rst = 1'b0;
          end
        join
        idle(20);
        check("f0 dropped", 32'(rxif.valid), 0);
        send(8'h0F, 1'b1);
        check("0f data", 32'(rxif.data), 32'h0F);
        rdy_dir = 1'b1;
        idle(20);

        // Back-to-back with nobody accepting.
        rdy_dir = 1'b0;
        ov0 = ov_cnt;
        send(8'h3C, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        idle(5);
        check("b2b data", 32'(rxif.data), 32'h3C);
        check("b2b overruns", 32'(ov_cnt - ov0), 2);
        rdy_dir = 1'b1;
        idle(2);
        check("b2b drained", 32'(rxif.valid), 0);
        idle(20);

        // Accept coinciding with a new load.
        rdy_dir = 1'b0;
        send(8'h99, 1'b1);
        idle(5);
        ov0 = ov_cnt;
        fork
          send(8'h66, 1'b1);
          begin
            repeat (LAT - 1) @(posedge clk);
            #1 rdy_dir = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("swap valid", 32'(rxif.valid), 1);
            check("swap data", 32'(rxif.data), 32'h66);
          end
        join
        check("swap overrun", 32'(ov_cnt - ov0), 0);
        idle(20);

        // Random frames, gaps and ready.
        rr_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
          w  = 8'($urandom);
          ok = ($urandom_range(0, 7) != 0);
          send(w, ok);
          idle(ok ? $urandom_range(0, 12) : $urandom_range(3, 15));
        end
        rr_en = 1'b0;
        rdy_dir = 1'b1;
        idle(20);
      end
      begin
        forever begin
          @(negedge clk);
          if (frame_err === 1'b1) fe_cnt++;
          if (overrun === 1'b1) ov_cnt++;
          n_chk++;
          if (rxif.valid !== valid_m || rxif.data !== data_m ||
              frame_err !== fe_m || overrun !== ov_m) begin
            n_fail++;
            if (n_fail <= 20)
              $display("FAIL cycle %0d v/d/fe/ov got %b/%h/%b/%b exp %b/%h/%b/%b",
                       cyc, rxif.valid, rxif.data, frame_err, overrun,
                       valid_m, data_m, fe_m, ov_m);
          end
        end
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
